// File: rtl/le18_ram_arbiter.sv
// le18_ram_arbiter
// Shares LE18 RAM port A between the Z80 (port-0xEC strobe) and the host
// loader. Only one access is in flight at a time. The Z80 always wins
// arbitration. A Z80 strobe that arrives while the arbiter is busy is parked
// in a single pending slot. If the slot is already occupied, the strobe is
// dropped and a sticky overflow flag is set.
//
// Access timing, with the request seen in cycle N:
//   write: ISSUE (N+1) -> DONE (N+2)
//   read : ISSUE (N+1) -> REG (N+2, ram_oce) -> CAPT (N+3, ram_dout latched)
//          -> DONE (N+4)
// DONE always returns to IDLE, where the next access is arbitrated.
//
// Ports:
//   clk, srst                    clock and synchronous active-high reset
//   z80_req/we/addr/wdata        one-cycle Z80 access strobe and its fields
//   z80_rdata, z80_rdy           Z80 read data (held) and completion pulse
//   z80_ovf                      sticky flag for a dropped Z80 request
//   host_req/we/addr/wdata       level-held host loader request
//   host_addr_ld                 host address-counter load strobe
//   host_ack, host_rdata         host completion pulse and read data (held)
//   ram_ce/we/oce/addr/din       RAM port-A controls
//   ram_dout                     RAM port-A output-register data
//
// Configuration macro: LE18_HOST_AUTOINC_EN
//   When this macro is defined, host accesses use an internal address
//   counter. host_addr_ld loads the counter from host_addr, and the counter
//   increments on every host_ack. When the macro is undefined, host
//   accesses use host_addr directly.
module le18_ram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              z80_req,
  input  logic              z80_we,
  input  logic [ADDR_W-1:0] z80_addr,
  input  logic [DATA_W-1:0] z80_wdata,
  output logic [DATA_W-1:0] z80_rdata,
  output logic              z80_rdy,
  output logic              z80_ovf,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_addr_ld,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_ce,
  output logic              ram_we,
  output logic              ram_oce,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] REG   = 3'd2;
  localparam logic [2:0] CAPT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              pendValid_q, pendValid_d;
  logic              pendWe_q;
  logic [ADDR_W-1:0] pendAddr_q;
  logic [DATA_W-1:0] pendData_q;
  logic              accZ80_q;
  logic              accWe_q;
  logic [ADDR_W-1:0] accAddr_q;
  logic [DATA_W-1:0] accData_q;
  logic [DATA_W-1:0] z80Rdata_q;
  logic [DATA_W-1:0] hostRdata_q;
  logic              z80Ovf_q;
  logic              grantZ80;
  logic              grantHost;
  logic [ADDR_W-1:0] hostAddrEff;

`ifdef LE18_HOST_AUTOINC_EN
  logic [ADDR_W-1:0] hostCnt_q;

  // A load in the host_ack cycle takes priority over the increment.
  // The counter wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (srst) begin
      hostCnt_q <= '0;
    end else if (host_addr_ld) begin
      hostCnt_q <= host_addr;
    end else if (host_ack) begin
      hostCnt_q <= hostCnt_q + 1'b1;
    end
  end

  assign hostAddrEff = hostCnt_q;
`else
  logic unusedHostAddrLd;
  assign unusedHostAddrLd = host_addr_ld;
  assign hostAddrEff      = host_addr;
`endif

  // The Z80 is granted from the pending slot, or directly from a live strobe
  // seen in IDLE. The host is granted only when no Z80 work exists at all.
  always_comb begin
    grantZ80    = (state_q == IDLE) && (pendValid_q || z80_req);
    grantHost   = (state_q == IDLE) && !pendValid_q && !z80_req && host_req;
    pendValid_d = grantZ80 ? 1'b0 : (pendValid_q || z80_req);
    state_d     = state_q;
    case (state_q)
      IDLE:    if (grantZ80 || grantHost) state_d = ISSUE;
      ISSUE:   state_d = accWe_q ? DONE : REG;
      REG:     state_d = CAPT;
      CAPT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // This block holds the pending slot, the access register captured at grant,
  // read-data capture and the overflow flag. A strobe that arrives while the
  // slot is full is dropped. This also applies in IDLE, where the parked
  // access is granted in the same cycle.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      pendValid_q <= 1'b0;
      pendWe_q    <= 1'b0;
      pendAddr_q  <= '0;
      pendData_q  <= '0;
      accZ80_q    <= 1'b0;
      accWe_q     <= 1'b0;
      accAddr_q   <= '0;
      accData_q   <= '0;
      z80Rdata_q  <= '0;
      hostRdata_q <= '0;
      z80Ovf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pendValid_q <= pendValid_d;
      if (z80_req && !pendValid_q && !grantZ80) begin
        pendWe_q   <= z80_we;
        pendAddr_q <= z80_addr;
        pendData_q <= z80_wdata;
      end
      if (z80_req && pendValid_q) begin
        z80Ovf_q <= 1'b1;
      end
      if (grantZ80) begin
        accZ80_q  <= 1'b1;
        accWe_q   <= pendValid_q ? pendWe_q   : z80_we;
        accAddr_q <= pendValid_q ? pendAddr_q : z80_addr;
        accData_q <= pendValid_q ? pendData_q : z80_wdata;
      end else if (grantHost) begin
        accZ80_q  <= 1'b0;
        accWe_q   <= host_we;
        accAddr_q <= hostAddrEff;
        accData_q <= host_wdata;
      end
      if (state_q == CAPT) begin
        if (accZ80_q) z80Rdata_q  <= ram_dout;
        else          hostRdata_q <= ram_dout;
      end
    end
  end

  assign ram_ce     = (state_q == ISSUE);
  assign ram_we     = (state_q == ISSUE) && accWe_q;
  assign ram_oce    = (state_q == REG);
  assign ram_addr   = accAddr_q;
  assign ram_din    = accData_q;
  assign z80_rdy    = (state_q == DONE) && accZ80_q;
  assign host_ack   = (state_q == DONE) && !accZ80_q;
  assign z80_rdata  = z80Rdata_q;
  assign host_rdata = hostRdata_q;
  assign z80_ovf    = z80Ovf_q;

endmodule
